// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared types and constants for the RISC-Y control sequencer
package risc_pkg;

  localparam int OP_WIDTH    = 3;
  localparam int PHASE_WIDTH = 3;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  typedef enum logic [PHASE_WIDTH-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  // Opcodes that read a memory operand and write the accumulator.
  function automatic logic is_aluop(opcode_t op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/risc_phase_counter.sv
// rtl/risc_phase_counter.sv - wrapping 8-phase instruction-cycle counter with hold
module risc_phase_counter
  import risc_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   hold,
  output phase_t phase
);

  phase_t phase_q;
  phase_t phase_d;

  always_comb begin
    phase_d = phase_q;
    if (!hold) begin
      phase_d = phase_t'(PHASE_WIDTH'(phase_q) + PHASE_WIDTH'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= INST_ADDR;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/risc_sequencer.sv
// rtl/risc_sequencer.sv - multi-cycle control sequencer: phase stepping, halt and control decode
module risc_sequencer
  import risc_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [OP_WIDTH-1:0]    OPCODE,
  input  logic                   ZERO,
  output logic                   SEL,
  output logic                   RD,
  output logic                   WR,
  output logic                   LD_IR,
  output logic                   LD_AC,
  output logic                   LD_PC,
  output logic                   INC_PC,
  output logic                   HALT,
  output logic                   DATA_E,
  output logic [PHASE_WIDTH-1:0] PHASE
);

  opcode_t op;
  phase_t  phase;
  logic    halted_q;
  logic    halted_d;
  logic    alu;

  assign op  = opcode_t'(OPCODE);
  assign alu = is_aluop(op);

  always_comb begin
    halted_d = halted_q;
    if (phase == OP_ADDR && op == OP_HLT) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  // Holding on the next-state flag keeps the phase at OP_ADDR on the entry edge itself.
  risc_phase_counter u_phase_counter (
    .clk   (CLK),
    .rst_n (RST_N),
    .hold  (halted_d),
    .phase (phase)
  );

  assign PHASE = PHASE_WIDTH'(phase);

  always_comb begin
    SEL    = 1'b0;
    RD     = 1'b0;
    WR     = 1'b0;
    LD_IR  = 1'b0;
    LD_AC  = 1'b0;
    LD_PC  = 1'b0;
    INC_PC = 1'b0;
    HALT   = 1'b0;
    DATA_E = 1'b0;
    if (halted_q) begin
      HALT = 1'b1;
    end else begin
      case (phase)
        INST_ADDR: begin
          SEL = 1'b1;
        end
        INST_FETCH: begin
          SEL = 1'b1;
          RD  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          SEL   = 1'b1;
          RD    = 1'b1;
          LD_IR = 1'b1;
        end
        OP_ADDR: begin
          INC_PC = 1'b1;
          HALT   = (op == OP_HLT);
        end
        OP_FETCH: begin
          RD = alu;
        end
        ALU_OP: begin
          RD     = alu;
          INC_PC = (op == OP_SKZ) && ZERO;
          LD_PC  = (op == OP_JMP);
          DATA_E = (op == OP_STO);
        end
        STORE: begin
          RD     = alu;
          LD_AC  = alu;
          INC_PC = (op == OP_JMP);
          LD_PC  = (op == OP_JMP);
          WR     = (op == OP_STO);
          DATA_E = (op == OP_STO);
        end
        default: begin
          SEL = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_risc_sequencer.sv
// tb/tb_risc_sequencer.sv - directed and randomized checks of risc_sequencer against a phase-table model
module tb_risc_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [2:0] OPCODE;
  logic       ZERO;
  logic       SEL, RD, WR, LD_IR, LD_AC, LD_PC, INC_PC, HALT, DATA_E;
  logic [2:0] PHASE;

  int n_cmp = 0;
  int n_err = 0;
  int m_phase;
  bit m_halted;
  logic [2:0] cur_op;

  always #5 CLK = ~CLK;

  risc_sequencer dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .OPCODE (OPCODE),
    .ZERO   (ZERO),
    .SEL    (SEL),
    .RD     (RD),
    .WR     (WR),
    .LD_IR  (LD_IR),
    .LD_AC  (LD_AC),
    .LD_PC  (LD_PC),
    .INC_PC (INC_PC),
    .HALT   (HALT),
    .DATA_E (DATA_E),
    .PHASE  (PHASE)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (model phase %0d halted %0d)", tag, obs, exp, m_phase, m_halted);
    end
  endtask

  // Expected controls {SEL,RD,WR,LD_IR,LD_AC,LD_PC,INC_PC,HALT,DATA_E} from the phase table.
  function automatic logic [8:0] model_ctrl(int p, bit h, int op, bit z);
    bit alu, sel, rd, wr, ldir, ldac, ldpc, inc, hlt, de;
    if (h) return 9'b0_0000_0010;
    alu  = (op == 2) || (op == 3) || (op == 4) || (op == 5);
    sel  = (p < 4);
    rd   = (p >= 1 && p <= 3) || (p >= 5 && alu);
    ldir = (p == 2) || (p == 3);
    ldac = (p == 7) && alu;
    ldpc = (p >= 6) && (op == 7);
    inc  = (p == 4) || (p == 6 && op == 1 && z) || (p == 7 && op == 7);
    hlt  = (p == 4) && (op == 0);
    wr   = (p == 7) && (op == 6);
    de   = (p >= 6) && (op == 6);
    return {sel, rd, wr, ldir, ldac, ldpc, inc, hlt, de};
  endfunction

  task automatic step(input bit rst, input logic [2:0] op, input bit z);
    logic [8:0] e;
    RST_N  = rst;
    OPCODE = op;
    ZERO   = z;
    @(negedge CLK);
    e = model_ctrl(m_phase, m_halted, int'(op), z);
    check_eq("PHASE",  32'(PHASE),  32'(m_phase));
    check_eq("SEL",    32'(SEL),    32'(e[8]));
    check_eq("RD",     32'(RD),     32'(e[7]));
    check_eq("WR",     32'(WR),     32'(e[6]));
    check_eq("LD_IR",  32'(LD_IR),  32'(e[5]));
    check_eq("LD_AC",  32'(LD_AC),  32'(e[4]));
    check_eq("LD_PC",  32'(LD_PC),  32'(e[3]));
    check_eq("INC_PC", 32'(INC_PC), 32'(e[2]));
    check_eq("HALT",   32'(HALT),   32'(e[1]));
    check_eq("DATA_E", 32'(DATA_E), 32'(e[0]));
    @(posedge CLK);
    if (!rst) begin
      m_phase  = 0;
      m_halted = 0;
    end else if (!m_halted) begin
      if (m_phase == 4 && op == 3'd0) m_halted = 1;
      else m_phase = (m_phase + 1) % 8;
    end
    #1;
  endtask

  task automatic run_instr(input logic [2:0] op, input bit z);
    for (int i = 0; i < 8; i++) step(1'b1, op, z);
  endtask

  initial begin
    RST_N  = 1'b0;
    OPCODE = 3'd2;
    ZERO   = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    m_phase  = 0;
    m_halted = 0;

    step(1'b0, 3'd2, 1'b0);
    run_instr(3'd2, 1'b0);
    run_instr(3'd6, 1'b1);
    run_instr(3'd1, 1'b1);
    run_instr(3'd1, 1'b0);
    run_instr(3'd7, 1'b0);
    run_instr(3'd5, 1'b1);

    for (int i = 0; i < 6; i++) step(1'b1, 3'd7, 1'b0);
    step(1'b0, 3'd7, 1'b0);
    run_instr(3'd3, 1'b1);

    run_instr(3'd0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, (i < 10) ? 3'd0 : 3'd2, 1'($urandom_range(0, 1)));
    step(1'b0, 3'd2, 1'b0);
    run_instr(3'd4, 1'b0);

    cur_op = 3'd2;
    for (int i = 0; i < 3000; i++) begin
      bit rst;
      if (m_phase < 4 || m_halted) cur_op = 3'($urandom_range(0, 7));
      rst = m_halted ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 59) != 0);
      step(rst, cur_op, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
